// File: rtl/dsm_pkg.sv
// Shared types and default sizing for the DSM sample feeder.
package dsm_pkg;

    localparam int unsigned DSM_DATA_WIDTH  = 16;
    localparam int unsigned DSM_DEPTH       = 8;
    localparam int unsigned DSM_PRIME_LEVEL = 4;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/dsm_fifo_mem.sv
// Sample storage: DEPTH x DATA_WIDTH register array, one write port, async read.
module dsm_fifo_mem #(
    parameter  int unsigned DATA_WIDTH = 16,
    parameter  int unsigned DEPTH      = 8,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/dsm_sample_feeder.sv
// Pops one buffered sample per clk_en strobe towards the modulator; primes the
// FIFO before running and drops back to priming on an underrun.
module dsm_sample_feeder
    import dsm_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = DSM_DATA_WIDTH,
    parameter  int unsigned DEPTH       = DSM_DEPTH,
    parameter  int unsigned PRIME_LEVEL = DSM_PRIME_LEVEL,
    localparam int unsigned ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                         clk_in,
    input  logic                         rst,
    input  logic                         clk_en,
    input  logic signed [DATA_WIDTH-1:0] s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic signed [DATA_WIDTH-1:0] sample_out,
    output logic                         sample_stb,
    output logic [ADDR_WIDTH:0]          level,
    output logic                         running,
    output logic                         underrun,
    input  logic                         underrun_clr
);

    localparam int unsigned LW = ADDR_WIDTH + 1;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    feeder_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    sample_t               sample_out_q, sample_out_d;
    logic                  sample_stb_q, sample_stb_d;
    logic                  running_q, running_d;
    logic                  underrun_q, underrun_d;

    logic                  push_c;
    logic                  pop_c;
    logic                  starve_c;
    sample_t               head_c;

    dsm_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk_i      (clk_in),
        .wr_en_i    (push_c),
        .wr_addr_i  (wr_ptr_q),
        .wr_data_i  (s_data),
        .rd_addr_i  (rd_ptr_q),
        .rd_data_o  (head_c)
    );

    // A push landing in an empty FIFO is not visible to a same-cycle strobe.
    assign s_ready  = (level_q != LW'(DEPTH));
    assign push_c   = s_valid && s_ready;
    assign pop_c    = (state_q == RUN) && clk_en && (level_q != '0);
    assign starve_c = (state_q == RUN) && clk_en && (level_q == '0);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        sample_out_d = sample_out_q;
        sample_stb_d = 1'b0;
        underrun_d   = underrun_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop_c) begin
            rd_ptr_d     = rd_ptr_q + ADDR_WIDTH'(1);
            sample_out_d = head_c;
            sample_stb_d = 1'b1;
        end

        case ({push_c, pop_c})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A fresh underrun takes priority over a clear in the same cycle.
        if (starve_c) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end

        unique case (state_q)
            PRIME: begin
                if (level_q >= LW'(PRIME_LEVEL)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (starve_c) begin
                    state_d = PRIME;
                end
            end
            default: state_d = PRIME;
        endcase

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q      <= PRIME;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            sample_out_q <= '0;
            sample_stb_q <= 1'b0;
            running_q    <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            sample_out_q <= sample_out_d;
            sample_stb_q <= sample_stb_d;
            running_q    <= running_d;
            underrun_q   <= underrun_d;
        end
    end

    assign sample_out = sample_out_q;
    assign sample_stb = sample_stb_q;
    assign level      = level_q;
    assign running    = running_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_dsm_sample_feeder.sv
// Directed bench for dsm_sample_feeder: priming, popping, full/empty edges,
// underrun handling, pointer wrap and asynchronous reset.
module tb_dsm_sample_feeder;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] sample_out;
    logic        sample_stb;
    logic [3:0]  level;
    logic        running;
    logic        underrun;
    logic        underrun_clr;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_q[$];
    logic [15:0] exp_v;

    dsm_sample_feeder dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .clk_en       (clk_en),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .sample_out   (sample_out),
        .sample_stb   (sample_stb),
        .level        (level),
        .running      (running),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs applied at a falling edge, consumed by the next rising edge.
    task automatic step(input logic v, input logic [15:0] d, input logic en, input logic clr);
        s_valid      = v;
        s_data       = d;
        clk_en       = en;
        underrun_clr = clr;
        @(negedge clk_in);
        s_valid      = 1'b0;
        clk_en       = 1'b0;
        underrun_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        clk_en       = 1'b0;
        s_data       = '0;
        s_valid      = 1'b0;
        underrun_clr = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("rst_level", 32'(level), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_sample", 32'(sample_out), 0);
        chk("rst_stb", 32'(sample_stb), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_ready", 32'(s_ready), 1);
        rst = 1'b0;

        // Three samples never reach the prime level; strobes are ignored.
        for (int i = 0; i < 3; i++) step(1'b1, 16'(10 + i), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("prime_stb", 32'(sample_stb), 0);
            chk("prime_running", 32'(running), 0);
            for (int j = 0; j < 3; j++) begin
                step(1'b0, '0, 1'b0, 1'b0);
                chk("prime_stb_idle", 32'(sample_stb), 0);
            end
        end
        chk("prime_sample", 32'(sample_out), 0);
        chk("prime_level", 32'(level), 3);
        chk("prime_underrun", 32'(underrun), 0);

        // Prime with 1..4, then pop them one strobe at a time.
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        chk("prime4_running_early", 32'(running), 0);
        chk("prime4_level", 32'(level), 4);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("prime4_running", 32'(running), 1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("pop_sample", 32'(sample_out), 32'(i));
            chk("pop_stb", 32'(sample_stb), 1);
            chk("pop_level", 32'(level), 32'(4 - i));
            step(1'b0, '0, 1'b0, 1'b0);
            chk("pop_stb_low", 32'(sample_stb), 0);
        end

        // Strobe on an empty FIFO in RUN.
        step(1'b0, '0, 1'b1, 1'b0);
        chk("ur_flag", 32'(underrun), 1);
        chk("ur_running", 32'(running), 0);
        chk("ur_sample_hold", 32'(sample_out), 4);
        chk("ur_stb", 32'(sample_stb), 0);
        for (int i = 5; i <= 8; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        chk("reprime_running_early", 32'(running), 0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("reprime_running", 32'(running), 1);
        chk("ur_sticky", 32'(underrun), 1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("ur_clear", 32'(underrun), 0);
        for (int i = 5; i <= 8; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("back2back_sample", 32'(sample_out), 32'(i));
            chk("back2back_stb", 32'(sample_stb), 1);
        end
        // Push into empty with strobe and clear together: still an underrun.
        step(1'b1, 16'd99, 1'b1, 1'b1);
        chk("ur_set_wins", 32'(underrun), 1);
        chk("ur_nobypass_running", 32'(running), 0);
        chk("ur_nobypass_level", 32'(level), 1);
        chk("ur_nobypass_stb", 32'(sample_stb), 0);
        chk("ur_nobypass_sample", 32'(sample_out), 8);

        // Fill to DEPTH and try one more.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 16'(100 + i), 1'b0, 1'b0);
        chk("full_level", 32'(level), 8);
        chk("full_ready", 32'(s_ready), 0);
        step(1'b1, 16'd999, 1'b0, 1'b0);
        chk("full_reject_level", 32'(level), 8);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("full_pop_sample", 32'(sample_out), 100);
        chk("full_pop_level", 32'(level), 7);
        chk("full_pop_ready", 32'(s_ready), 1);

        // Simultaneous push and pop, then wrap the pointers many times.
        for (int i = 1; i < 8; i++) model_q.push_back(16'(100 + i));
        for (int i = 0; i < 2; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            exp_v = model_q.pop_front();
            chk("drain_sample", 32'(sample_out), 32'(exp_v));
        end
        chk("drain_level", 32'(level), 5);
        step(1'b1, 16'd200, 1'b1, 1'b0);
        exp_v = model_q.pop_front();
        model_q.push_back(16'd200);
        chk("pushpop_sample", 32'(sample_out), 32'(exp_v));
        chk("pushpop_level", 32'(level), 5);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'(300 + i), 1'b1, 1'b0);
            exp_v = model_q.pop_front();
            model_q.push_back(16'(300 + i));
            chk("wrap_sample", 32'(sample_out), 32'(exp_v));
        end
        chk("wrap_level", 32'(level), 5);
        chk("wrap_underrun", 32'(underrun), 0);

        // Asynchronous reset away from any rising edge.
        step(1'b1, 16'd500, 1'b0, 1'b0);
        chk("mid_level", 32'(level), 6);
        #2;
        rst = 1'b1;
        #1;
        chk("async_level", 32'(level), 0);
        chk("async_sample", 32'(sample_out), 0);
        chk("async_running", 32'(running), 0);
        chk("async_stb", 32'(sample_stb), 0);
        @(negedge clk_in);
        rst = 1'b0;
        step(1'b0, '0, 1'b1, 1'b0);
        chk("post_rst_level", 32'(level), 0);
        chk("post_rst_underrun", 32'(underrun), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
